// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - instruction fields and datapath controls between mc_ctrl and the datapath
//
// Purpose: bundles the IR fields the controller decodes and the control
// signals it returns to the register file, ALU, memory and next-PC unit.
// Modports:
//   master - the control unit: reads opcode/funct/rt, drives all controls
//   slave  - the datapath: drives opcode/funct/rt, reads all controls
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       PCwr;
  logic       IRwr;
  logic       RegWr;
  logic       MemWr;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       ExtOp;
  logic [2:0] ALUop;
  logic       Jump;
  logic [1:0] btype;

  modport master (
    input  opcode, funct, rt,
    output PCwr, IRwr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg, ExtOp,
           ALUop, Jump, btype
  );

  modport slave (
    output opcode, funct, rt,
    input  PCwr, IRwr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg, ExtOp,
           ALUop, Jump, btype
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle main control unit for the MIPS-subset CPU
//
// Purpose: decodes the IR and steps each instruction through IF/ID/EXE/MEM/WB,
// pulsing PCwr exactly once per instruction in its final state.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high
//   bus      - mc_ctrl_if.master: opcode/funct/rt in, datapath controls out
//   state    - current FSM state (debug)
//   illegal  - one-cycle pulse in ID for an undefined instruction
//   retired  - count of PCwr pulses, wraps
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_ctrl_if.master        bus,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_retired;

  // Instruction decode
  logic w_rtype, w_addu, w_subu, w_slt;
  logic w_ori, w_lui, w_lw, w_sw;
  logic w_beq, w_bne, w_bltz, w_j;
  logic w_branch, w_legal;

  assign w_rtype  = (bus.opcode == 6'b000000);
  assign w_addu   = w_rtype && (bus.funct == 6'b100001);
  assign w_subu   = w_rtype && (bus.funct == 6'b100011);
  assign w_slt    = w_rtype && (bus.funct == 6'b101010);
  assign w_ori    = (bus.opcode == 6'b001101);
  assign w_lui    = (bus.opcode == 6'b001111);
  assign w_lw     = (bus.opcode == 6'b100011);
  assign w_sw     = (bus.opcode == 6'b101011);
  assign w_beq    = (bus.opcode == 6'b000100);
  assign w_bne    = (bus.opcode == 6'b000101);
  // REGIMM opcode is only bltz when rt is zero; other rt values are undefined here
  assign w_bltz   = (bus.opcode == 6'b000001) && (bus.rt == 5'b00000);
  assign w_j      = (bus.opcode == 6'b000010);
  assign w_branch = w_beq | w_bne | w_bltz;
  assign w_legal  = w_addu | w_subu | w_slt | w_ori | w_lui | w_lw | w_sw |
                    w_branch | w_j;

  // Datapath selects are pure decode, valid in every state, so the
  // next-PC inputs are already settled whenever PCwr fires.
  always_comb begin
    bus.ALUop = 3'b000;
    if (w_subu | w_branch) bus.ALUop = 3'b001;
    else if (w_ori)        bus.ALUop = 3'b010;
    else if (w_slt)        bus.ALUop = 3'b011;
    else if (w_lui)        bus.ALUop = 3'b100;

    bus.btype = 2'b00;
    if (w_beq)       bus.btype = 2'b01;
    else if (w_bne)  bus.btype = 2'b10;
    else if (w_bltz) bus.btype = 2'b11;
  end

  assign bus.ALUSrc   = w_ori | w_lui | w_lw | w_sw;
  assign bus.RegDst   = w_rtype;
  assign bus.MemtoReg = w_lw;
  assign bus.ExtOp    = w_lw | w_sw | w_branch;
  assign bus.Jump     = w_j;

  // Sequencing
  logic [2:0] w_next_state;
  logic       w_pcwr, w_irwr, w_regwr, w_memwr, w_illegal;

  always_comb begin
    w_next_state = S_IF;
    w_pcwr       = 1'b0;
    w_irwr       = 1'b0;
    w_regwr      = 1'b0;
    w_memwr      = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_IF: begin
        w_irwr       = 1'b1;
        w_next_state = S_ID;
      end
      S_ID: begin
        if (w_j) begin
          w_pcwr       = 1'b1;
          w_next_state = S_IF;
        end else if (!w_legal) begin
          // Undefined instruction is skipped: PC advances, nothing else written
          w_pcwr       = 1'b1;
          w_illegal    = 1'b1;
          w_next_state = S_IF;
        end else begin
          w_next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (w_branch) begin
          w_pcwr       = 1'b1;
          w_next_state = S_IF;
        end else if (w_lw | w_sw) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (w_sw) begin
          w_memwr      = 1'b1;
          w_pcwr       = 1'b1;
          w_next_state = S_IF;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        w_regwr      = 1'b1;
        w_pcwr       = 1'b1;
        w_next_state = S_IF;
      end
      default: w_next_state = S_IF;
    endcase
  end

  // Enables are masked while reset is held so nothing is written mid-reset
  assign bus.PCwr  = w_pcwr  & ~reset;
  assign bus.IRwr  = w_irwr  & ~reset;
  assign bus.RegWr = w_regwr & ~reset;
  assign bus.MemWr = w_memwr & ~reset;
  assign illegal   = w_illegal & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if (bus.PCwr) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main control unit for the MIPS-subset CPU. It decodes the instruction held in the instruction register and sequences each instruction through the fetch, decode, execute, memory and write-back states. It drives the next-PC unit (`PCwr`, `Jump`, `btype`) so the PC advances exactly once per instruction, in that instruction's final state. It also drives the datapath write enables and ALU selects, and keeps a retired-instruction counter.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `opcode` input, 6 bits: IR[31:26], stable from the end of IF until the next IF.
- `funct` input, 6 bits: IR[5:0].
- `rt` input, 5 bits: IR[20:16], used to qualify bltz.
- `PCwr` output, 1 bit: PC write enable to the next-PC unit.
- `IRwr` output, 1 bit: instruction register load enable.
- `RegWr` output, 1 bit: register file write enable.
- `MemWr` output, 1 bit: data memory write enable.
- `RegDst` output, 1 bit: selects the destination register; 1 = rd, 0 = rt.
- `ALUSrc` output, 1 bit: ALU operand B select; 1 = extended immediate, 0 = rt register.
- `MemtoReg` output, 1 bit: write-back data select; 1 = memory, 0 = ALU.
- `ExtOp` output, 1 bit: immediate extension; 1 = sign-extend, 0 = zero-extend.
- `ALUop` output, 3 bits: 000 add, 001 sub, 010 or, 011 slt, 100 lui.
- `Jump` output, 1 bit: selects the jump target in the next-PC unit.
- `btype` output, 2 bits: 00 none, 01 beq, 10 bne, 11 bltz.
- `state` output, 3 bits: current FSM state, for debug.
- `illegal` output, 1 bit: one-cycle pulse in ID when the opcode/funct is undefined.
- `retired` output, CNT_W bits: count of PCwr pulses.

## Operation
**Decoded instructions**
- R-type (opcode 000000): funct 100001 addu, 100011 subu, 101010 slt.
- I-type: ori 001101, lui 001111, lw 100011, sw 101011.
- Branches: beq 000100, bne 000101, bltz 000001 (only with rt = 00000).
- Jump: j 000010.
- Anything else is illegal.

**States** (IF=0, ID=1, EXE=2, MEM=3, WB=4; codes 5–7 return to IF)
- IF: `IRwr`=1, then go to ID.
- ID:
  - j: `PCwr`=1, `Jump`=1, go to IF.
  - illegal: `PCwr`=1 (the instruction is skipped), `illegal`=1, go to IF.
  - All others: go to EXE.
- EXE:
  - Branches: `PCwr`=1, go to IF. The branch decision is made by the next-PC unit from Zero/Sign and `btype`.
  - R-type, ori, lui: go to WB.
  - lw, sw: go to MEM.
- MEM:
  - sw: `MemWr`=1, `PCwr`=1, go to IF.
  - lw: go to WB.
- WB: `RegWr`=1, `PCwr`=1, go to IF.

**Decode outputs** (combinational from `opcode`/`funct`/`rt`, valid in every state)
- `ALUop`: addu, lw, sw → add; subu, beq, bne, bltz → sub; ori → or; slt → slt; lui → lui.
- `ALUSrc`=1 for ori, lui, lw, sw.
- `RegDst`=1 for R-type only.
- `MemtoReg`=1 for lw only.
- `ExtOp`=1 for lw, sw, beq, bne, bltz; 0 for ori and lui.
- `btype` follows the opcode for branches and is 00 otherwise; `Jump`=1 for j.
- `PCwr` may only be high in states where the next-PC unit's inputs are final, so `btype`/`Jump` are held for the whole instruction.

**Write enables**
- `PCwr`, `IRwr`, `RegWr`, `MemWr` and `illegal` are state-qualified and otherwise 0.
- At most one of `RegWr`/`MemWr` is high in any cycle, and `PCwr` is high in exactly one cycle per instruction.

**Counter**
- `retired` increments on every clock edge where `PCwr`=1 and wraps from 2^CNT_W−1 to 0.

## Timing
- Cycles per instruction: j 2, illegal 2, beq/bne/bltz 3, sw 4, R-type/ori/lui 4, lw 5.
- The next-PC unit captures the new PC on the same edge that moves this FSM to IF; the next IF then fetches at the new PC.
- Reset:
  - Asynchronous; `state` = IF and `retired` = 0 immediately.
  - While `reset` is high, `PCwr`, `IRwr`, `RegWr`, `MemWr` and `illegal` are forced to 0.
  - The first IF after deassertion loads the IR at PC=0.
- Reset mid-instruction abandons the instruction with no further register or memory writes and no counter increment.
- An `opcode` change outside IF is not expected; outputs track it combinationally, with no latching.

## Test plan
- **Reset:** assert `reset` for 3 cycles, release. Required: `state`=0 and `IRwr`=1 in the first cycle, all other enables 0, `retired`=0.
- **Sequence addu, ori, lw, sw, beq, j:**
  - Required state traces: 0-1-2-4, 0-1-2-4, 0-1-2-3-4, 0-1-2-3, 0-1-2, 0-1.
  - `retired` = 6 after 22 cycles.
  - Exactly one `PCwr` pulse per instruction.
- **bltz decode:**
  - opcode 000001 with rt=00000 → `btype`=11, `ALUop`=001, `PCwr` in EXE.
  - opcode 000001 with rt=00001 → `illegal` pulse in ID, `PCwr` in ID.
- **Undefined funct:** opcode 000000 with funct 000000 → `illegal`=1 for one cycle, no `RegWr`, return to IF after 2 cycles.
- **Reset during lw MEM:** assert `reset` in state 3. Required: `state`=0 at once, no `RegWr` ever asserted for that lw, `retired` unchanged at 0.
- **Counter wrap:** CNT_W=4, run 17 j instructions. Required: `retired` goes 15 → 0 → 1.
